// File: rtl/shift_reg_ctrl.sv
// Purpose : sequences one external shift register out onto a 74HC595-style serial bus (ser_clk/ser_dat/ser_latch).
// Latency : a frame takes 1 + 2*CLK_DIV*BIT_WIDTH + CLK_DIV cycles from the first LOAD cycle to the done pulse.
// Backpr. : no backpressure; start is sampled only in IDLE, and a start that arrives while busy is dropped, not queued.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               frame request (sampled in IDLE only)
//   auto_refresh        chain the next frame straight after done (no IDLE gap)
//   sr_q0               Q[0] of the controlled shift register
//   sr_shiftn_loadp     1 = load par_in, 0 = shift (only meaningful with sr_step)
//   sr_shift_in         serial fill for the register, tied to 0
//   sr_step             one-cycle update enable for the register
//   ser_clk/ser_dat/ser_latch  board-side serial display bus
//   busy                high from LOAD through the last LATCH cycle
//   done                one-cycle pulse on the final LATCH cycle
module shift_reg_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic auto_refresh,
  input  logic sr_q0,
  output logic sr_shiftn_loadp,
  output logic sr_shift_in,
  output logic sr_step,
  output logic ser_clk,
  output logic ser_dat,
  output logic ser_latch,
  output logic busy,
  output logic done
);

  localparam int BW = $clog2(BIT_WIDTH);
  // A one-cycle divider still needs a 1-bit counter to keep the vector legal.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] BIT_MAX = BW'(BIT_WIDTH - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_LATCH
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            div_last;
  logic            dat_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
    end
  end

  assign div_last = (div_q == DIV_MAX);

  // Zero-fill keeps a stale bit from reappearing if the register is ever
  // stepped past the frame end.
  assign sr_shift_in = 1'b0;

  // The only combinational path from the register: the bus sees Q[0]
  // directly while a bit is on the wire, so no extra pipeline stage is needed
  // between the shift and the next LOW phase.
  assign ser_dat = dat_en & sr_q0;

  always_comb begin
    state_d         = state_q;
    div_d           = div_q;
    bit_d           = bit_q;
    sr_shiftn_loadp = 1'b0;
    sr_step         = 1'b0;
    ser_clk         = 1'b0;
    ser_latch       = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    dat_en          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (start) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        sr_shiftn_loadp = 1'b1;
        sr_step         = 1'b1;
        busy            = 1'b1;
        state_d         = S_LOW;
        div_d           = '0;
        bit_d           = '0;
      end

      S_LOW: begin
        busy   = 1'b1;
        dat_en = 1'b1;
        if (div_last) begin
          state_d = S_HIGH;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_HIGH: begin
        busy    = 1'b1;
        ser_clk = 1'b1;
        dat_en  = 1'b1;
        if (div_last) begin
          div_d = '0;
          if (bit_q == BIT_MAX) begin
            // Last bit already on the wire: no further shift, go latch.
            state_d = S_LATCH;
            bit_d   = '0;
          end else begin
            // Shift on the final HIGH cycle so ser_dat only changes as
            // ser_clk falls, well after the receiver's rising-edge sample.
            // bit_idx carries across LOW/HIGH; only the divider restarts.
            sr_step = 1'b1;
            bit_d   = bit_q + BW'(1);
            state_d = S_LOW;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_LATCH: begin
        busy      = 1'b1;
        ser_latch = 1'b1;
        if (div_last) begin
          done    = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = auto_refresh ? S_LOAD : S_IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
module tb_shift_reg_ctrl;

  localparam int W         = 8;
  localparam int D         = 2;
  localparam int FRAME_LEN = 1 + 2 * D * W + D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         auto_refresh = 1'b0;
  logic [W-1:0] par_in = '0;
  logic [W-1:0] sr_model = '0;
  logic         sr_q0;
  logic         sr_shiftn_loadp, sr_shift_in, sr_step;
  logic         ser_clk, ser_dat, ser_latch, busy, done;

  shift_reg_ctrl #(.BIT_WIDTH(W), .CLK_DIV(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .auto_refresh    (auto_refresh),
    .sr_q0           (sr_q0),
    .sr_shiftn_loadp (sr_shiftn_loadp),
    .sr_shift_in     (sr_shift_in),
    .sr_step         (sr_step),
    .ser_clk         (ser_clk),
    .ser_dat         (ser_dat),
    .ser_latch       (ser_latch),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // The controlled shift register (board-side plant, not the reference).
  always @(posedge clk) begin
    if (sr_step) begin
      sr_model <= sr_shiftn_loadp ? par_in : {sr_shift_in, sr_model[W-1:1]};
    end
  end
  assign sr_q0 = sr_model[0];

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] word;
    bit           abort;
    int           abort_len;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   pushed = 0;
  int   seen   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [W-1:0] w, input bit ab, input int alen);
    exp_t e;
    e.word      = w;
    e.abort     = ab;
    e.abort_len = alen;
    sb.push_back(e);
    pushed++;
  endtask

  // ---------------- monitor ----------------
  bit           mon_en = 1'b0;
  int           cyc = 0, nbits = 0, nstep = 0, nload = 0, nshift = 0;
  int           latch_cnt = 0, latch_first = 0;
  logic [W-1:0] cap = '0;
  bit           pos_err = 0, stab_err = 0, prev_clk = 0, prev_low = 0;
  bit           is_low = 0, low_dat = 0, expect_next = 0, exp_busy_next = 0;

  task automatic end_frame(input bit got_done);
    exp_t e;
    seen++;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL unexpected_frame: got a frame of %0d busy cycles, expected none", cyc);
    end else begin
      e = sb.pop_front();
      if (e.abort) begin
        chk("abort_len", cyc, e.abort_len);
        chk("abort_latch", latch_cnt, 0);
        chk("abort_done", got_done, 0);
      end else begin
        chk("frame_len", cyc, FRAME_LEN);
        chk("done_seen", got_done, 1);
        chk("ser_bits", cap, e.word);
        chk("bit_count", nbits, W);
        chk("step_count", nstep, W);
        chk("load_steps", nload, 1);
        chk("step_position", pos_err, 0);
        chk("data_stable", stab_err, 0);
        chk("latch_cycles", latch_cnt, D);
        chk("latch_first", latch_first, 2 * D * W + 2);
      end
    end
    cyc = 0; nbits = 0; nstep = 0; nload = 0; nshift = 0;
    latch_cnt = 0; latch_first = 0; cap = '0; pos_err = 0; stab_err = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (expect_next) begin
          expect_next = 0;
          chk("after_done_busy", busy, exp_busy_next);
          if (exp_busy_next) chk("chained_load", {sr_shiftn_loadp, sr_step}, 2'b11);
        end
        is_low = busy && !ser_clk && !ser_latch && !sr_shiftn_loadp;
        if (busy) begin
          cyc++;
          if (sr_shift_in) stab_err = 1;
          if (is_low) begin
            if (!prev_low) low_dat = ser_dat;
            else if (ser_dat != low_dat) stab_err = 1;
          end
          if (ser_clk) begin
            if (!prev_clk) begin
              if (nbits < W) cap[nbits] = ser_dat;
              nbits++;
            end
            if (ser_dat != low_dat) stab_err = 1;
          end
          if (ser_latch && (ser_dat || ser_clk)) stab_err = 1;
          if (sr_step) begin
            nstep++;
            if (sr_shiftn_loadp) begin
              nload++;
              if (cyc != 1) pos_err = 1;
            end else begin
              nshift++;
              // k-th shift lands on the last HIGH cycle of bit k-1
              if (cyc != 1 + 2 * D * nshift) pos_err = 1;
            end
          end
          if (ser_latch) begin
            if (latch_cnt == 0) latch_first = cyc;
            latch_cnt++;
          end
          if (done) begin
            expect_next   = 1;
            exp_busy_next = auto_refresh;
            end_frame(1'b1);
          end
        end else begin
          if (cyc > 0) end_frame(1'b0);
          chk("idle_outputs",
              {sr_shiftn_loadp, sr_shift_in, sr_step, ser_clk, ser_dat, ser_latch, done}, 7'b0);
        end
        prev_clk = ser_clk;
        prev_low = is_low;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // Issue one frame; optionally poke start again at busy cycle poke_at (0 = none).
  task automatic single_frame(input logic [W-1:0] w, input int poke_at);
    wait_idle();
    par_in = w;
    start  = 1'b1;
    expect_frame(w, 1'b0, 0);
    tick();
    start = 1'b0;
    if (poke_at >= 2) begin
      repeat (poke_at - 1) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    tick();
    wait_idle();
  endtask

  task automatic auto_pair(input logic [W-1:0] w0, input logic [W-1:0] w1);
    wait_idle();
    auto_refresh = 1'b1;
    par_in       = w0;
    start        = 1'b1;
    expect_frame(w0, 1'b0, 0);
    expect_frame(w1, 1'b0, 0);
    tick();
    start = 1'b0;
    tick();
    par_in = w1;
    repeat (FRAME_LEN - 1) tick();
    auto_refresh = 1'b0;
    tick();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] w;
    rst = 1'b1;
    repeat (3) tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    chk("reset_busy", busy, 0);
    repeat (20) tick();

    single_frame(8'hA5, 0);
    single_frame(8'h3C, 5);
    single_frame(8'hC3, 20);
    auto_pair(8'h0F, 8'hF0);

    // Reset while in HIGH of bit 2 (busy cycle 12).
    wait_idle();
    w      = W'($urandom);
    par_in = w;
    start  = 1'b1;
    expect_frame(w, 1'b1, 12);
    tick();
    start = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_ser_clk", ser_clk, 0);
    single_frame(W'($urandom), 0);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 2) == 0) auto_pair(W'($urandom), W'($urandom));
      else single_frame(W'($urandom), $urandom_range(0, 30));
    end

    wait_idle();
    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);
    chk("frames_seen", seen, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
